// File: rtl/mem_access_stage_if.sv
// Bundles the EX-side instruction handshake, the data-memory req/ack bus and the
// writeback outputs. The slave modport belongs to the stage; master is its environment.
interface mem_access_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // ex_valid/ex_ready: an instruction transfers on a rising edge where both are high;
  // mem_req/mem_ack: the request is held stable until an edge where both are high.
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ex_alu_result;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic [4:0]            ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [2:0]            ex_funct3;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  wb_valid;
  logic                  wb_reg_write;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_fault;

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_funct3, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_fault
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_funct3, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_fault
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: ALU results pass straight to writeback, loads/stores
// run against a variable-latency memory with lane alignment, extension and fault flagging.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_stage_if.slave  bus,
  output logic               dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [4:0]            rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  wb_fault_q, wb_fault_d;

  logic [1:0]            off;
  logic                  is_mem;
  logic [3:0]            acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_fault;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic [DATA_WIDTH-1:0] load_data;

  // Decode lanes, replicated store data and legality of the presented access.
  always_comb begin
    off       = bus.ex_alu_result[1:0];
    is_mem    = bus.ex_mem_read | bus.ex_mem_write;
    acc_be    = 4'b0000;
    acc_wdata = bus.ex_store_data;
    acc_fault = 1'b0;
    case (bus.ex_funct3)
      3'b000, 3'b100: begin
        acc_be    = 4'b0001 << off;
        acc_wdata = {4{bus.ex_store_data[7:0]}};
        acc_fault = bus.ex_funct3[2] & bus.ex_mem_write;
      end
      3'b001, 3'b101: begin
        acc_be    = 4'b0011 << off;
        acc_wdata = {2{bus.ex_store_data[15:0]}};
        acc_fault = off[0] | (bus.ex_funct3[2] & bus.ex_mem_write);
      end
      3'b010: begin
        acc_be    = 4'b1111;
        acc_fault = (off != 2'b00);
      end
      default: acc_fault = 1'b1;
    endcase
  end

  always_comb begin
    rdata_shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_fault_d     = wb_fault_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = bus.ex_reg_write;
            wb_rd_d        = bus.ex_rd;
            wb_data_d      = bus.ex_alu_result;
            wb_fault_d     = 1'b0;
          end else if (acc_fault) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_rd_d        = bus.ex_rd;
            wb_data_d      = bus.ex_alu_result;
            wb_fault_d     = 1'b1;
          end else begin
            state_d     = BUSY;
            mem_we_d    = bus.ex_mem_write;
            mem_addr_d  = {bus.ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = acc_wdata;
            mem_be_d    = acc_be;
            funct3_d    = bus.ex_funct3;
            off_d       = off;
            rd_d        = bus.ex_rd;
            reg_write_d = bus.ex_reg_write;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_d;
          wb_fault_d = 1'b0;
          // A completed store reports its full byte address on wb_data.
          if (mem_we_q) begin
            wb_reg_write_d = 1'b0;
            wb_data_d      = DATA_WIDTH'({mem_addr_q[ADDR_WIDTH-1:2], off_q});
          end else begin
            wb_reg_write_d = reg_write_q;
            wb_data_d      = load_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= 4'b0000;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
      rd_q           <= 5'd0;
      reg_write_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
      wb_fault_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_fault_q     <= wb_fault_d;
    end
  end

  // mem_req is decoded from state so an asynchronous reset drops it at once.
  assign bus.ex_ready     = (state_q == IDLE);
  assign bus.mem_req      = (state_q == BUSY);
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_fault     = wb_fault_q;
  assign dbg_state_o      = state_q;

endmodule
